// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared constants, FSM state type and counter-width helper for
//            the SPI responder.
// Revision : 1.0
// ============================================================================
package spi_pkg;

   localparam int SPI_DATA_W = 8;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_t;

   function automatic int spi_cnt_w(input int data_w);
      return (data_w > 2) ? $clog2(data_w) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync
// Purpose  : Multi-flop synchroniser followed by a rise/fall edge detector.
// Revision : 1.0
// ============================================================================
module spi_sync #(
   parameter int SYNC_STAGES = 2,
   parameter bit RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], din};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
   assign fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : SPI Mode-0 responder, oversampled in the clk domain, with a
//            one-entry tx holding buffer. Define SPI_SLAVE_MSB_FIRST_EN for
//            MSB-first framing (LSB-first otherwise).
// Revision : 1.0
// ============================================================================
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              ss_n,
   output logic              miso,
   output logic              miso_en,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun
);

   localparam int                 c_CNT_W = spi_cnt_w(DATA_W);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

   logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk  (clk),
      .rst  (rst),
      .din  (sclk),
      .rise (w_sclk_rise),
      .fall (w_sclk_fall)
   );

   // ss_n idles high, so its chain resets high to avoid a phantom edge
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk  (clk),
      .rst  (rst),
      .din  (ss_n),
      .rise (w_ss_rise),
      .fall (w_ss_fall)
   );

   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   w_mosi;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_mosi_sync <= '0;
      else      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
   end

   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   spi_state_t          r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_shreg, w_shifted, w_load_data, r_buf;
   logic [c_CNT_W-1:0]  r_bitcnt;
   logic                r_full, r_reload, r_rx_done;
   logic                w_load, w_shift, w_abort, w_last, w_accept;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ss_fall) begin
               w_state_nxt = ST_ACTIVE;
               w_load      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (w_ss_rise) begin
               w_state_nxt = ST_IDLE;
               w_abort     = 1'b1;
            end else if (w_sclk_rise) begin
               w_shift = 1'b1;
            end else if (w_sclk_fall && r_reload) begin
               w_load = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_last      = w_shift && (r_bitcnt == c_LAST);
   assign w_load_data = r_full ? r_buf : '0;
   assign w_accept    = tx_valid & ~r_full;

`ifdef SPI_SLAVE_MSB_FIRST_EN
   assign w_shifted = {r_shreg[DATA_W-2:0], w_mosi};
   assign miso      = (r_state == ST_ACTIVE) ? r_shreg[DATA_W-1] : 1'b0;
`else
   assign w_shifted = {w_mosi, r_shreg[DATA_W-1:1]};
   assign miso      = (r_state == ST_ACTIVE) ? r_shreg[0] : 1'b0;
`endif

   assign miso_en  = (r_state == ST_ACTIVE);
   assign tx_ready = ~r_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_bitcnt    <= '0;
         r_reload    <= 1'b0;
         r_buf       <= '0;
         r_full      <= 1'b0;
         rx_data     <= '0;
         r_rx_done   <= 1'b0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_load)       r_shreg <= w_load_data;
         else if (w_shift) r_shreg <= w_shifted;

         if (w_load || w_abort) r_bitcnt <= '0;
         else if (w_shift)      r_bitcnt <= w_last ? '0 : r_bitcnt + c_CNT_W'(1);

         if (w_load || w_abort) r_reload <= 1'b0;
         else if (w_last)       r_reload <= 1'b1;

         // A consume and an accept in one cycle leave the new byte held
         if (w_accept) r_buf <= tx_data;
         r_full <= w_accept | (r_full & ~w_load);

         if (w_last) rx_data <= w_shifted;
         r_rx_done   <= w_last;
         rx_valid    <= r_rx_done;
         tx_underrun <= w_load & ~r_full;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_if
// Purpose  : Directed self-checking bench for spi_slave_if (Mode 0 master).
// Revision : 1.0
// ============================================================================
module tb_spi_slave_if;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       sclk     = 1'b0;
   logic       mosi     = 1'b0;
   logic       ss_n     = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       miso, miso_en, tx_ready, rx_valid, tx_underrun;
   logic [7:0] rx_data;

   spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .mosi        (mosi),
      .ss_n        (ss_n),
      .miso        (miso),
      .miso_en     (miso_en),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_underrun (tx_underrun)
   );

   always #5 clk = ~clk;

   int n_cmp     = 0;
   int n_err     = 0;
   int rx_pulses = 0;
   int ur_pulses = 0;

   always @(negedge clk) begin
      if (rx_valid)    rx_pulses++;
      if (tx_underrun) ur_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic ss_low();
      ss_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic ss_high();
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Mode 0: data set while sclk low, miso sampled just before the rise
   task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         int pos;
`ifdef SPI_SLAVE_MSB_FIRST_EN
         pos = 7 - i;
`else
         pos = i;
`endif
         mosi = mo[pos];
         repeat (6) @(negedge clk);
         mi[pos] = miso;
         sclk = 1'b1;
         repeat (8) @(negedge clk);
         sclk = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] mi;
      int r0, u0;

      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_miso",     miso,        1'b0);
      check("rst_miso_en",  miso_en,     1'b0);
      check("rst_tx_ready", tx_ready,    1'b1);
      check("rst_rx_data",  rx_data,     8'h00);
      check("rst_rx_valid", rx_valid,    1'b0);
      check("rst_underrun", tx_underrun, 1'b0);

      // Single frame: tx A5, rx 3C
      push(8'hA5);
      check("t1_ready_full", tx_ready, 1'b0);
      r0 = rx_pulses;
      ss_low();
      check("t1_miso_en",  miso_en,  1'b1);
      check("t1_tx_ready", tx_ready, 1'b1);
      spi_bits(8'h3C, 8, mi);
      check("t1_miso_byte", mi,              8'hA5);
      check("t1_rx_data",   rx_data,         8'h3C);
      check("t1_rx_pulses", rx_pulses - r0,  1);
      ss_high();
      check("t1_miso_en_off", miso_en, 1'b0);

      // Back-to-back frames under one ss_n low
      push(8'h01);
      r0 = rx_pulses;
      u0 = ur_pulses;
      ss_low();
      push(8'h80);
      spi_bits(8'hFF, 8, mi);
      check("t2_miso_f1", mi,      8'h01);
      check("t2_rx_f1",   rx_data, 8'hFF);
      push(8'h00);
      spi_bits(8'h00, 8, mi);
      check("t2_miso_f2",   mi,             8'h80);
      check("t2_rx_f2",     rx_data,        8'h00);
      check("t2_rx_pulses", rx_pulses - r0, 2);
      check("t2_underrun",  ur_pulses - u0, 0);
      ss_high();

      // Empty buffer at frame start
      u0 = ur_pulses;
      ss_low();
      check("t3_underrun", ur_pulses - u0, 1);
      spi_bits(8'h96, 8, mi);
      check("t3_miso_zero", mi,      8'h00);
      check("t3_rx_data",   rx_data, 8'h96);
      ss_high();

      // Aborted frame after 5 bits, then a full frame
      r0 = rx_pulses;
      ss_low();
      spi_bits(8'h77, 5, mi);
      ss_high();
      check("t4_abort_pulses", rx_pulses - r0, 0);
      check("t4_abort_en",     miso_en,        1'b0);
      check("t4_abort_rx",     rx_data,        8'h96);
      ss_low();
      spi_bits(8'h5A, 8, mi);
      check("t4_rx_data",   rx_data,        8'h5A);
      check("t4_rx_pulses", rx_pulses - r0, 1);
      ss_high();

      // Reset mid-frame
      push(8'h11);
      ss_low();
      spi_bits(8'hF0, 4, mi);
      rst = 1'b0;
      @(negedge clk);
      check("t5_rst_miso",     miso,        1'b0);
      check("t5_rst_miso_en",  miso_en,     1'b0);
      check("t5_rst_ready",    tx_ready,    1'b1);
      check("t5_rst_rx_data",  rx_data,     8'h00);
      check("t5_rst_rx_valid", rx_valid,    1'b0);
      check("t5_rst_underrun", tx_underrun, 1'b0);
      ss_n = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      push(8'h22);
      r0 = rx_pulses;
      ss_low();
      spi_bits(8'hC3, 8, mi);
      check("t5_miso_byte",  mi,             8'h22);
      check("t5_rx_data",    rx_data,        8'hC3);
      check("t5_rx_pulses",  rx_pulses - r0, 1);
      ss_high();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
